// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared opcodes, sequencer state encoding and timer sizing helper.
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_NOR = 8'h27;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WAIT_B  = 3'd1;
  localparam state_t ST_WAIT_OP = 3'd2;
  localparam state_t ST_EXEC    = 3'd3;
  localparam state_t ST_WAIT_TX = 3'd4;

  // A disabled timeout (0 cycles) still needs a 1-bit counter to stay legal.
  function automatic int timer_width(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : frame_timer
// Purpose  : Loadable saturating down-counter flagging inter-byte timeout.
// Revision : 1.0
// ============================================================================
module frame_timer
  import alu_pkg::*;
#(
  parameter int LOAD_VALUE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = timer_width(LOAD_VALUE);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= CNT_W'(LOAD_VALUE);
    end else if (count_en) begin
      if (r_count != '0) r_count <= r_count - 1'b1;
    end else begin
      r_count <= '0;
    end
  end

  // Reaching zero means LOAD_VALUE idle cycles have already elapsed.
  assign expired = (LOAD_VALUE != 0) && count_en && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/alu_uart_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_uart_sequencer
// Purpose  : Collects A/B/opcode bytes from UART, feeds ALU, sends result.
// Revision : 1.0
// ============================================================================
module alu_uart_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done_tick,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  tx_done_tick,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [DATA_WIDTH-1:0] alu_op,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  frame_error,
  output logic                  overrun
);

  state_t r_state;
  logic   w_in_frame;
  logic   w_accept;
  logic   w_load;
  logic   w_expired;

  assign w_in_frame = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
  assign w_accept   = rx_done_tick && ((r_state == ST_IDLE) || w_in_frame);
  // Reload whenever a byte moves us into (or onward within) a timed state.
  assign w_load     = w_accept && (r_state != ST_WAIT_OP);

  frame_timer #(
    .LOAD_VALUE (TIMEOUT_CYCLES)
  ) u_frame_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .count_en (w_in_frame),
    .expired  (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      frame_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rx_done_tick) begin
            alu_a   <= rx_data;
            overrun <= 1'b0;
            r_state <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (rx_done_tick) begin
            alu_b   <= rx_data;
            r_state <= ST_WAIT_OP;
          end else if (w_expired) begin
            frame_error <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        ST_WAIT_OP: begin
          if (rx_done_tick) begin
            alu_op  <= rx_data;
            r_state <= ST_EXEC;
          end else if (w_expired) begin
            frame_error <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          tx_data  <= alu_result;
          tx_start <= 1'b1;
          r_state  <= ST_WAIT_TX;
          if (rx_done_tick) overrun <= 1'b1;
        end
        ST_WAIT_TX: begin
          if (rx_done_tick) overrun <= 1'b1;
          // A done strobe coincident with our own start belongs to a prior byte.
          if (tx_done_tick && !tx_start) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/alu_uart_sequencer.md
# alu_uart_sequencer

Frame sequencer between the UART receiver/transmitter pair and the 8-bit combinational ALU. It collects three received bytes in order (operand A, operand B, opcode) and holds them as registered ALU inputs. It then captures the ALU result one cycle later and hands it to the UART transmitter with a single-cycle start strobe. Inter-byte timeouts and bytes arriving while a result is in flight are flagged rather than silently corrupting the frame.

## Interface
- `DATA_WIDTH`, 8: width of operands, opcode, result and UART data.
- `TIMEOUT_CYCLES`, 50_000_000: maximum idle clock cycles allowed between bytes of one frame. 0 disables the timeout.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_done_tick`  in  1  one-cycle strobe: `rx_data` valid.
- `rx_data`  in  DATA_WIDTH  received byte.
- `tx_done_tick`  in  1  one-cycle strobe: transmitter finished the current byte.
- `alu_result`  in  DATA_WIDTH  ALU output (combinational function of `alu_a`/`alu_b`/`alu_op`).
- `alu_a`, `alu_b`, `alu_op`  out  DATA_WIDTH each  registered ALU operands and opcode.
- `tx_start`  out  1  one-cycle strobe: transmit `tx_data`.
- `tx_data`  out  DATA_WIDTH  registered result byte.
- `busy`  out  1  high in every state except IDLE.
- `frame_error`  out  1  one-cycle pulse on timeout abort.
- `overrun`  out  1  sticky: a byte was dropped during EXEC/WAIT_TX.

## Operation
- States: IDLE, WAIT_B, WAIT_OP, EXEC, WAIT_TX.
- IDLE: on `rx_done_tick`, `alu_a` <= `rx_data`, `overrun` <= 0, go to WAIT_B.
- WAIT_B: on `rx_done_tick`, `alu_b` <= `rx_data`, go to WAIT_OP.
- WAIT_OP: on `rx_done_tick`, `alu_op` <= `rx_data`, go to EXEC.
- EXEC (exactly one cycle): `tx_data` <= `alu_result`, `tx_start` <= 1, go to WAIT_TX.
- WAIT_TX: `tx_start` returns to 0 after one cycle. On `tx_done_tick`, go to IDLE.
  - `tx_done_tick` in the same cycle `tx_start` is high is ignored.
- Opcodes are not validated. An unsupported opcode is forwarded, and the ALU's 0x00 result is transmitted.
- Timeout (WAIT_B, WAIT_OP only):
  - The counter clears on entry and on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES` with no `rx_done_tick`, go to IDLE and pulse `frame_error` for one cycle.
  - `alu_a`/`alu_b`/`alu_op` keep their stale values.
- `rx_done_tick` and timeout expiry in the same cycle: the byte wins and no error is raised.
- `rx_done_tick` in EXEC or WAIT_TX: byte dropped, `overrun` <= 1. It stays set until the next byte is accepted in IDLE, or until reset.
- `tx_done_tick` outside WAIT_TX is ignored.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0: `alu_a`, `alu_b`, `alu_op`, `tx_data`, `tx_start`, `busy`, `frame_error`, `overrun`.
  - Timeout counter 0.
- Reset asserted mid-frame or mid-transmit aborts immediately to IDLE. No `tx_start` is issued afterwards.
- Let edge N accept the opcode byte:
  - EXEC is the cycle N..N+1.
  - `tx_start` = 1 and `tx_data` valid in the cycle following edge N+1.
  - `tx_start` = 0 after edge N+2.
- `tx_data` holds its value until the next EXEC.
- `busy` rises the cycle after the A byte is accepted. It falls the cycle after `tx_done_tick` is accepted in WAIT_TX.
- Back-to-back frames are supported: the A byte of the next frame is accepted in the first IDLE cycle.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`. It saturates and does not wrap.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, SRA 0x03, SRL 0x02, NOR 0x27. These are shared with the ALU and testbench.
  - State encoding typedef.
  - `DATA_WIDTH` default.
- One sub-module, `frame_timer`: loadable/clearable saturating down-counter with an `expired` output. It is instantiated once.
- FSM and output registers live in the top module. The ALU is instantiated outside, at the top level.

## Test plan
- Bytes 0x05, 0x03, 0x20, with ALU stub = add:
  - `tx_start` pulses once, 2 cycles after the opcode strobe, with `tx_data` = 0x08.
  - `tx_done_tick` -> `busy` = 0.
- Bytes 0xF0, 0x02, 0x03 (SRA) -> `tx_data` = 0xFC. Bytes 0x01, 0x01, 0x55 (invalid opcode) -> `tx_data` = 0x00 with a normal handshake.
- TIMEOUT_CYCLES = 16; send 0x05, then nothing for 16 cycles:
  - `frame_error` pulses once and the FSM is in IDLE.
  - A following 0x07, 0x02, 0x22 -> `tx_data` = 0x05.
- Frame 0x05, 0x03, 0x20, then byte 0xAA during WAIT_TX:
  - `overrun` = 1, `tx_data` stays 0x08.
  - The next accepted byte clears `overrun`.
- Assert `reset` in WAIT_OP and during WAIT_TX: all outputs 0 within the same cycle, and no `tx_start` afterwards.
- Two frames back-to-back, A byte strobed the cycle after `tx_done_tick`: both results transmitted correctly in order.
